// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//
// Purpose:
//    Parallel-to-serial UART-style frame transmitter. One accepted byte is sent
//    as a frame: start bit (0), eight data bits LSB first, an optional
//    even-parity bit, and a stop bit (1). Every bit is held on the line for
//    CLKS_PER_BIT clock cycles. done pulses for one cycle in the first idle
//    cycle after the stop bit. A new byte can be accepted in that same cycle,
//    so back-to-back frames have exactly one idle-high cycle between them.
//
// Parameters:
//    CLKS_PER_BIT  clock cycles per serial bit, legal range 2..255
//    PARITY_EN     1 = insert an even-parity bit after the data, 0 = no parity
//
// Ports:
//    clk       in   single clock, rising-edge active
//    rst       in   asynchronous, active-high reset
//    tx_data   in   [7:0] byte to transmit
//    tx_valid  in   tx_data is offered for transmission
//    tx_ready  out  block can accept a byte this cycle (IDLE only)
//    txd       out  serial line, idle-high, driven straight from a flop
//    busy      out  a frame is in progress
//    done      out  one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module serial_frame_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic       parity_q, parity_d;
   logic       txd_q, txd_d;
   logic       done_q, done_d;
   logic       bit_end;

   // The last cycle of the current bit; every non-IDLE state advances here.
   assign bit_end = (cnt_q == LAST_CNT);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. DATA leaves only after bit index 7 has been held for a
   // full bit time, so the 3-bit index never wraps into a ninth data bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end && (idx_q == 3'd7)) begin
               state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath registers: bit-time counter, data bit index, shift register,
   // latched parity, and the registered line and done outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= 8'd0;
         idx_q    <= 3'd0;
         shift_q  <= 8'd0;
         parity_q <= 1'b0;
         txd_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         txd_q    <= txd_d;
         done_q   <= done_d;
      end
   end

   // Datapath next values. The byte and its parity are captured only while
   // IDLE, so tx_data/tx_valid activity during a frame is ignored. Parity is
   // taken at accept time because the shift register is consumed as bits go.
   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      if (state_q == IDLE) begin
         cnt_d = 8'd0;
         idx_d = 3'd0;
         if (tx_valid) begin
            shift_d  = tx_data;
            parity_d = ^tx_data;
         end
      end else if (bit_end) begin
         cnt_d = 8'd0;
         if (state_q == DATA) begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
         end
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Output logic. txd is precomputed from the next state so the line flop
   // already shows the new bit in the first cycle of each state; this keeps
   // txd a pure register output with no input-to-output combinational path.
   always_comb begin
      tx_ready = (state_q == IDLE);
      busy     = (state_q != IDLE);
      done_d   = (state_q == STOP) && bit_end;
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = parity_d;
         default: txd_d = 1'b1;
      endcase
   end

   assign txd  = txd_q;
   assign done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Three transmitter instances share one clock and reset:
//    unit 0: CLKS_PER_BIT=4, PARITY_EN=1
//    unit 1: CLKS_PER_BIT=4, PARITY_EN=0
//    unit 2: CLKS_PER_BIT=2, PARITY_EN=1
// Expected line waveforms are built from the frame definition (start, data
// LSB first, optional even parity, stop) as a list of bit slots, each slot
// lasting CLKS_PER_BIT cycles, with done in the cycle after the last slot.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data_r [3];
   logic       tx_valid_r [3];
   logic [2:0] tx_ready_w;
   logic [2:0] txd_w;
   logic [2:0] busy_w;
   logic [2:0] done_w;

   int vec_count;
   int miscompare_count;

   serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data_r[0]),
      .tx_valid (tx_valid_r[0]),
      .tx_ready (tx_ready_w[0]),
      .txd      (txd_w[0]),
      .busy     (busy_w[0]),
      .done     (done_w[0])
   );

   serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data_r[1]),
      .tx_valid (tx_valid_r[1]),
      .tx_ready (tx_ready_w[1]),
      .txd      (txd_w[1]),
      .busy     (busy_w[1]),
      .done     (done_w[1])
   );

   serial_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1)) u_dut2 (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data_r[2]),
      .tx_valid (tx_valid_r[2]),
      .tx_ready (tx_ready_w[2]),
      .txd      (txd_w[2]),
      .busy     (busy_w[2]),
      .done     (done_w[2])
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int cpbOf(input int u);
      return (u == 2) ? 2 : 4;
   endfunction

   function automatic int penOf(input int u);
      return (u == 1) ? 0 : 1;
   endfunction

   task automatic applyStimulus(input int u, input logic [7:0] data, input logic valid);
      tx_data_r[u]  = data;
      tx_valid_r[u] = valid;
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      vec_count++;
      assert (observed === expected) else begin
         miscompare_count++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input int u, input string tag);
      checkOutput($sformatf("%s u%0d txd", tag, u), txd_w[u], 1'b1);
      checkOutput($sformatf("%s u%0d tx_ready", tag, u), tx_ready_w[u], 1'b1);
      checkOutput($sformatf("%s u%0d busy", tag, u), busy_w[u], 1'b0);
      checkOutput($sformatf("%s u%0d done", tag, u), done_w[u], 1'b0);
   endtask

   // Sends one byte on unit u starting from an idle (or done) cycle, checks
   // the full line waveform, and returns in the done cycle after driving
   // next_data/next_valid (next_valid=1 chains another frame). If chg_cycle
   // is nonzero, tx_data is changed to chg_data and tx_valid raised in that
   // frame cycle to show the frame in flight is unaffected.
   task automatic runFrame(input int u, input logic [7:0] data,
                           input int chg_cycle, input logic [7:0] chg_data,
                           input logic next_valid, input logic [7:0] next_data);
      int   cpb;
      int   total;
      logic exp_bits[$];
      cpb = cpbOf(u);
      exp_bits = {};
      exp_bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) begin
         exp_bits.push_back(((int'(data) >> b) & 1) == 1);
      end
      if (penOf(u) != 0) begin
         int ones;
         ones = 0;
         for (int b = 0; b < 8; b++) begin
            ones += (int'(data) >> b) & 1;
         end
         exp_bits.push_back((ones % 2) == 1);
      end
      exp_bits.push_back(1'b1);
      total = exp_bits.size() * cpb;

      checkOutput($sformatf("u%0d ready before %h", u, data), tx_ready_w[u], 1'b1);
      applyStimulus(u, data, 1'b1);
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         checkOutput($sformatf("u%0d %h txd c%0d", u, data, k), txd_w[u], exp_bits[(k - 1) / cpb]);
         checkOutput($sformatf("u%0d %h busy c%0d", u, data, k), busy_w[u], 1'b1);
         checkOutput($sformatf("u%0d %h tx_ready c%0d", u, data, k), tx_ready_w[u], 1'b0);
         checkOutput($sformatf("u%0d %h done c%0d", u, data, k), done_w[u], 1'b0);
         if (k == 1) begin
            applyStimulus(u, data, 1'b0);
         end
         if ((chg_cycle != 0) && (k == chg_cycle)) begin
            applyStimulus(u, chg_data, 1'b1);
         end
      end
      @(negedge clk);
      checkOutput($sformatf("u%0d %h done c%0d", u, data, total + 1), done_w[u], 1'b1);
      checkOutput($sformatf("u%0d %h txd c%0d", u, data, total + 1), txd_w[u], 1'b1);
      checkOutput($sformatf("u%0d %h tx_ready c%0d", u, data, total + 1), tx_ready_w[u], 1'b1);
      checkOutput($sformatf("u%0d %h busy c%0d", u, data, total + 1), busy_w[u], 1'b0);
      applyStimulus(u, next_data, next_valid);
   endtask

   initial begin
      logic [7:0] rnd_byte;
      logic [7:0] rnd_next;
      int         u;

      vec_count        = 0;
      miscompare_count = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(i, 8'h00, 1'b0);
      end

      // Reset state before any clock edge.
      #2;
      for (int i = 0; i < 3; i++) begin
         checkIdle(i, "async reset");
      end

      // A byte offered while reset is held across rising edges is not taken.
      applyStimulus(0, 8'hA5, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checkIdle(0, "valid under reset");
      rst = 1'b0;

      // 0xA5 with parity: bits 1,0,1,0,0,1,0,1, parity 0, done in cycle 45.
      runFrame(0, 8'hA5, 0, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      checkIdle(0, "after A5");

      // 0x07 with parity 1, then 0x07 without parity slot (done cycle 41).
      runFrame(0, 8'h07, 0, 8'h00, 1'b0, 8'h00);
      runFrame(1, 8'h07, 0, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      checkIdle(1, "after 07 nopar");

      // Back-to-back 0x55 then 0xAA with tx_valid held high.
      runFrame(0, 8'h55, 0, 8'h00, 1'b1, 8'hAA);
      runFrame(0, 8'hAA, 0, 8'h00, 1'b0, 8'h00);

      // tx_data changed to 0xFF (with tx_valid high) mid-DATA of 0x3C.
      runFrame(0, 8'h3C, 20, 8'hFF, 1'b0, 8'h00);
      @(negedge clk);
      checkIdle(0, "after 3C");

      // 0x00 at two clocks per bit: done in cycle 23.
      runFrame(2, 8'h00, 0, 8'h00, 1'b0, 8'h00);

      // Reset pulsed during data bit 3 (frame cycles 17..20) of 0x37, whose
      // bit 3 is 0 so the asynchronous return of txd to 1 is visible.
      applyStimulus(0, 8'h37, 1'b1);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 1) begin
            applyStimulus(0, 8'h37, 1'b0);
         end
      end
      checkOutput("abort pre txd", txd_w[0], 1'b0);
      checkOutput("abort pre busy", busy_w[0], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkIdle(0, "abort async");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         checkOutput($sformatf("abort no done c%0d", k), done_w[0], 1'b0);
         checkOutput($sformatf("abort line c%0d", k), txd_w[0], 1'b1);
      end
      runFrame(0, 8'h81, 0, 8'h00, 1'b0, 8'h00);

      // Randomized single frames across all three configurations.
      for (int i = 0; i < 9; i++) begin
         u = i % 3;
         rnd_byte = 8'($urandom_range(0, 255));
         runFrame(u, rnd_byte, 0, 8'h00, 1'b0, 8'h00);
      end

      // Randomized back-to-back chain on unit 2.
      rnd_byte = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) begin
         rnd_next = 8'($urandom_range(0, 255));
         runFrame(2, rnd_byte, 0, 8'h00, (i != 3), rnd_next);
         rnd_byte = rnd_next;
      end
      @(negedge clk);
      checkIdle(2, "after chain");

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
      $finish;
   end

endmodule
